wb_commit_trace: RTL and testbench



---
 rtl/wb_commit_trace.sv | 208 ++++++++++++++++++++
 tb/tb_wb_commit_trace.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_commit_trace.sv
// wb_commit_trace: writeback stage of the 5-stage core.
//
// The block holds the MEM->WB pipeline register and decides when that entry
// commits. A commit drives the regfile write port and the HI/LO write bus,
// and pushes one record into a trace FIFO. Each entry commits exactly once,
// even while WB is held. When the trace FIFO is full, the block raises a
// pipeline stall request; it never drops a commit.
//
// Ports
//   clk, rst            clock and synchronous active-high reset
//   flush               clears the WB register
//   stall               pipeline stall vector; bit STALL_IDX belongs to this stage
//   in_*                instruction fields presented by MEM
//   rf_we/waddr/wbe/wdata   regfile write port (rf_we is commit-gated)
//   hilo_bus            {hi_we, lo_we, hi, lo} (write enables are commit-gated)
//   trace_valid/ready   handshake at the trace FIFO head
//   trace_pc/wen/wnum/wdata  trace record at the FIFO head
//   stallreq_wb         asks the pipeline to hold while an uncommitted entry waits
//   trace_count         trace FIFO occupancy
module wb_commit_trace #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned RF_AW       = 5,
  parameter int unsigned BE_W        = 4,
  parameter int unsigned STALL_W     = 6,
  parameter int unsigned STALL_IDX   = 4,
  parameter int unsigned TRACE_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [STALL_W-1:0]            stall,
  input  logic                          in_valid,
  input  logic [31:0]                   in_pc,
  input  logic                          in_rf_we,
  input  logic [RF_AW-1:0]              in_rf_waddr,
  input  logic [BE_W-1:0]               in_rf_wbe,
  input  logic [DATA_W-1:0]             in_rf_wdata,
  input  logic                          in_hi_we,
  input  logic                          in_lo_we,
  input  logic [DATA_W-1:0]             in_hi,
  input  logic [DATA_W-1:0]             in_lo,
  output logic                          rf_we,
  output logic [RF_AW-1:0]              rf_waddr,
  output logic [BE_W-1:0]               rf_wbe,
  output logic [DATA_W-1:0]             rf_wdata,
  output logic [2*DATA_W+1:0]           hilo_bus,
  output logic                          trace_valid,
  input  logic                          trace_ready,
  output logic [31:0]                   trace_pc,
  output logic [BE_W-1:0]               trace_wen,
  output logic [RF_AW-1:0]              trace_wnum,
  output logic [DATA_W-1:0]             trace_wdata,
  output logic                          stallreq_wb,
  output logic [$clog2(TRACE_DEPTH):0]  trace_count
);

  localparam int unsigned PC_W     = 32;
  localparam int unsigned PTR_W    = $clog2(TRACE_DEPTH);
  localparam int unsigned CNT_W    = PTR_W + 1;
  localparam int unsigned NEXT_IDX = STALL_IDX + 1;

  // WB pipeline register payload
  typedef struct packed {
    logic              valid;
    logic [PC_W-1:0]   pc;
    logic              rf_we;
    logic [RF_AW-1:0]  waddr;
    logic [BE_W-1:0]   wbe;
    logic [DATA_W-1:0] wdata;
    logic              hi_we;
    logic              lo_we;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } wb_reg_t;

  // One trace FIFO record
  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [BE_W-1:0]   wen;
    logic [RF_AW-1:0]  wnum;
    logic [DATA_W-1:0] wdata;
  } trace_ent_t;

  wb_reg_t    wb_q, wb_d;
  logic       committed_q, committed_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  trace_ent_t fifo_q [TRACE_DEPTH];
  trace_ent_t fifo_d [TRACE_DEPTH];

  logic       fifo_full_c;
  logic       fifo_empty_c;
  logic       commit_c;
  logic       push_c;
  logic       pop_c;
  trace_ent_t push_ent_c;
  trace_ent_t head_c;

  // Only two bits of the stall vector matter to this stage.
  logic unused_stall;
  assign unused_stall = ^stall;

  // Commit decision: occupancy only, never trace_ready, so pop-when-full
  // cannot open a same-cycle push.
  always_comb begin : commit_logic
    fifo_full_c  = (count_q == CNT_W'(TRACE_DEPTH));
    fifo_empty_c = (count_q == '0);
    commit_c     = wb_q.valid & ~committed_q & ~fifo_full_c;
    push_c       = commit_c;
    pop_c        = ~fifo_empty_c & trace_ready;
  end

  // WB register next state: flush, then load, then bubble, else hold.
  always_comb begin : wb_next
    wb_d        = wb_q;
    committed_d = committed_q;
    if (flush) begin
      wb_d        = '0;
      committed_d = 1'b0;
    end else if (!stall[STALL_IDX]) begin
      wb_d.valid  = in_valid;
      wb_d.pc     = in_pc;
      wb_d.rf_we  = in_rf_we;
      wb_d.waddr  = in_rf_waddr;
      wb_d.wbe    = in_rf_wbe;
      wb_d.wdata  = in_rf_wdata;
      wb_d.hi_we  = in_hi_we;
      wb_d.lo_we  = in_lo_we;
      wb_d.hi     = in_hi;
      wb_d.lo     = in_lo;
      committed_d = 1'b0;
    end else if (!stall[NEXT_IDX]) begin
      wb_d        = '0;
      committed_d = 1'b0;
    end else if (commit_c) begin
      // Held entry: remember it already committed so it never commits again.
      committed_d = 1'b1;
    end
  end

  // Trace FIFO next state
  always_comb begin : fifo_next
    push_ent_c.pc    = wb_q.pc;
    push_ent_c.wen   = wb_q.rf_we ? wb_q.wbe : '0;
    push_ent_c.wnum  = wb_q.waddr;
    push_ent_c.wdata = wb_q.wdata;

    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push_c) begin
      fifo_d[wr_ptr_q] = push_ent_c;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push_c && !pop_c) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push_c && pop_c) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // State registers
  always_ff @(posedge clk) begin : state_regs
    if (rst) begin
      wb_q        <= '0;
      committed_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      fifo_q      <= '{default: '0};
    end else begin
      wb_q        <= wb_d;
      committed_q <= committed_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      fifo_q      <= fifo_d;
    end
  end

  // Regfile and HI/LO write ports
  always_comb begin : write_ports
    rf_we    = commit_c & wb_q.rf_we;
    rf_waddr = wb_q.waddr;
    rf_wbe   = wb_q.wbe;
    rf_wdata = wb_q.wdata;
    hilo_bus = {commit_c & wb_q.hi_we, commit_c & wb_q.lo_we, wb_q.hi, wb_q.lo};
  end

  // Trace head; fields forced to zero while the FIFO is empty.
  always_comb begin : trace_out
    head_c      = fifo_q[rd_ptr_q];
    trace_valid = ~fifo_empty_c;
    trace_pc    = fifo_empty_c ? '0 : head_c.pc;
    trace_wen   = fifo_empty_c ? '0 : head_c.wen;
    trace_wnum  = fifo_empty_c ? '0 : head_c.wnum;
    trace_wdata = fifo_empty_c ? '0 : head_c.wdata;
    trace_count = count_q;
    stallreq_wb = wb_q.valid & ~committed_q & fifo_full_c;
  end

endmodule

// File: tb/tb_wb_commit_trace.sv
// Directed bench for wb_commit_trace: a table of per-cycle stimulus with
// hand-computed expected outputs, followed by a reset-mid-operation sequence.
module tb_wb_commit_trace;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [5:0]  stall;
  logic        in_valid;
  logic [31:0] in_pc;
  logic        in_rf_we;
  logic [4:0]  in_rf_waddr;
  logic [3:0]  in_rf_wbe;
  logic [31:0] in_rf_wdata;
  logic        in_hi_we, in_lo_we;
  logic [31:0] in_hi, in_lo;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [3:0]  rf_wbe;
  logic [31:0] rf_wdata;
  logic [65:0] hilo_bus;
  logic        trace_valid;
  logic        trace_ready;
  logic [31:0] trace_pc;
  logic [3:0]  trace_wen;
  logic [4:0]  trace_wnum;
  logic [31:0] trace_wdata;
  logic        stallreq_wb;
  logic [2:0]  trace_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wb_commit_trace dut (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall),
    .in_valid(in_valid), .in_pc(in_pc), .in_rf_we(in_rf_we),
    .in_rf_waddr(in_rf_waddr), .in_rf_wbe(in_rf_wbe), .in_rf_wdata(in_rf_wdata),
    .in_hi_we(in_hi_we), .in_lo_we(in_lo_we), .in_hi(in_hi), .in_lo(in_lo),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wbe(rf_wbe), .rf_wdata(rf_wdata),
    .hilo_bus(hilo_bus), .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_pc(trace_pc), .trace_wen(trace_wen), .trace_wnum(trace_wnum),
    .trace_wdata(trace_wdata), .stallreq_wb(stallreq_wb), .trace_count(trace_count)
  );

  typedef struct {
    logic        flush;
    logic [5:0]  stall;
    logic        valid;
    logic [31:0] pc;
    logic        we;
    logic [4:0]  waddr;
    logic [3:0]  wbe;
    logic [31:0] wdata;
    logic        hi_we, lo_we;
    logic [31:0] hi, lo;
    logic        ready;
    logic        e_we;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
    logic [65:0] e_hilo;
    logic [2:0]  e_cnt;
    logic        e_tv;
    logic [31:0] e_tpc;
    logic [3:0]  e_twen;
    logic [4:0]  e_twnum;
    logic        e_sreq;
  } vec_t;

  localparam logic [5:0] S0 = 6'b000000;
  localparam logic [5:0] SH = 6'b110000;
  localparam logic [5:0] SB = 6'b010000;

  vec_t tbl[$];

  function automatic vec_t row(
    input logic flush_i, input logic [5:0] stall_i, input logic valid_i,
    input logic [31:0] pc_i, input logic we_i, input logic [4:0] waddr_i,
    input logic [3:0] wbe_i, input logic [31:0] wdata_i, input logic ready_i,
    input logic e_we_i, input logic [4:0] e_waddr_i, input logic [31:0] e_wdata_i,
    input logic [2:0] e_cnt_i, input logic e_tv_i, input logic [31:0] e_tpc_i,
    input logic [3:0] e_twen_i, input logic [4:0] e_twnum_i, input logic e_sreq_i);
    vec_t v;
    v.flush = flush_i; v.stall = stall_i; v.valid = valid_i; v.pc = pc_i;
    v.we = we_i; v.waddr = waddr_i; v.wbe = wbe_i; v.wdata = wdata_i;
    v.hi_we = 1'b0; v.lo_we = 1'b0; v.hi = '0; v.lo = '0; v.ready = ready_i;
    v.e_we = e_we_i; v.e_waddr = e_waddr_i; v.e_wdata = e_wdata_i; v.e_hilo = '0;
    v.e_cnt = e_cnt_i; v.e_tv = e_tv_i; v.e_tpc = e_tpc_i; v.e_twen = e_twen_i;
    v.e_twnum = e_twnum_i; v.e_sreq = e_sreq_i;
    return v;
  endfunction

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    flush = v.flush; stall = v.stall; in_valid = v.valid; in_pc = v.pc;
    in_rf_we = v.we; in_rf_waddr = v.waddr; in_rf_wbe = v.wbe; in_rf_wdata = v.wdata;
    in_hi_we = v.hi_we; in_lo_we = v.lo_we; in_hi = v.hi; in_lo = v.lo;
    trace_ready = v.ready;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " rf_we"}, 66'(rf_we), '0);
    chk({tag, " rf_waddr"}, 66'(rf_waddr), '0);
    chk({tag, " rf_wbe"}, 66'(rf_wbe), '0);
    chk({tag, " rf_wdata"}, 66'(rf_wdata), '0);
    chk({tag, " hilo_bus"}, hilo_bus, '0);
    chk({tag, " trace_valid"}, 66'(trace_valid), '0);
    chk({tag, " trace_pc"}, 66'(trace_pc), '0);
    chk({tag, " trace_wen"}, 66'(trace_wen), '0);
    chk({tag, " trace_wnum"}, 66'(trace_wnum), '0);
    chk({tag, " trace_wdata"}, 66'(trace_wdata), '0);
    chk({tag, " stallreq_wb"}, 66'(stallreq_wb), '0);
    chk({tag, " trace_count"}, 66'(trace_count), '0);
  endtask

  initial begin
    vec_t v;
    vec_t idle;

    // Single ADDU, then drain
    tbl.push_back(row(0, S0, 1, 32'hBFC00010, 1, 5, 4'hF, 32'h12345678, 0,  1, 5, 32'h12345678, 0, 0, 0, 0, 0, 0));
    tbl.push_back(row(0, S0, 0, 0, 0, 0, 0, 0, 0,                          0, 0, 0, 1, 1, 32'hBFC00010, 4'hF, 5, 0));
    tbl.push_back(row(0, S0, 0, 0, 0, 0, 0, 0, 1,                          0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Held committed entry: one write, one record
    tbl.push_back(row(0, S0, 1, 32'hBFC00014, 1, 6, 4'h3, 32'hAAAA5555, 0, 1, 6, 32'hAAAA5555, 0, 0, 0, 0, 0, 0));
    tbl.push_back(row(0, SH, 1, 32'hDEADBEEF, 1, 31, 4'hF, 32'hDEADBEEF, 0, 0, 0, 0, 1, 1, 32'hBFC00014, 4'h3, 6, 0));
    tbl.push_back(row(0, SH, 1, 32'hDEADBEEF, 1, 31, 4'hF, 32'hDEADBEEF, 0, 0, 0, 0, 1, 1, 32'hBFC00014, 4'h3, 6, 0));
    tbl.push_back(row(0, SH, 1, 32'hDEADBEEF, 1, 31, 4'hF, 32'hDEADBEEF, 0, 0, 0, 0, 1, 1, 32'hBFC00014, 4'h3, 6, 0));
    tbl.push_back(row(0, S0, 0, 0, 0, 0, 0, 0, 1,                          0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Five back-to-back commits with the consumer stalled
    tbl.push_back(row(0, S0, 1, 32'h100, 1, 1, 4'hF, 32'h11, 0,            1, 1, 32'h11, 0, 0, 0, 0, 0, 0));
    tbl.push_back(row(0, S0, 1, 32'h104, 1, 2, 4'hF, 32'h22, 0,            1, 2, 32'h22, 1, 1, 32'h100, 4'hF, 1, 0));
    tbl.push_back(row(0, S0, 1, 32'h108, 1, 3, 4'hF, 32'h33, 0,            1, 3, 32'h33, 2, 1, 32'h100, 4'hF, 1, 0));
    tbl.push_back(row(0, S0, 1, 32'h10C, 1, 4, 4'hF, 32'h44, 0,            1, 4, 32'h44, 3, 1, 32'h100, 4'hF, 1, 0));
    tbl.push_back(row(0, S0, 1, 32'h110, 1, 9, 4'hF, 32'h55, 0,            0, 0, 0, 4, 1, 32'h100, 4'hF, 1, 1));
    tbl.push_back(row(0, SH, 1, 32'hDEADBEEF, 1, 31, 4'hF, 32'hDEADBEEF, 0, 0, 0, 0, 4, 1, 32'h100, 4'hF, 1, 1));
    tbl.push_back(row(0, SH, 1, 32'hDEADBEEF, 1, 31, 4'hF, 32'hDEADBEEF, 1, 1, 9, 32'h55, 3, 1, 32'h104, 4'hF, 2, 0));
    tbl.push_back(row(0, SH, 1, 32'hDEADBEEF, 1, 31, 4'hF, 32'hDEADBEEF, 0, 0, 0, 0, 4, 1, 32'h104, 4'hF, 2, 0));
    tbl.push_back(row(0, S0, 0, 0, 0, 0, 0, 0, 1,                          0, 0, 0, 3, 1, 32'h108, 4'hF, 3, 0));
    tbl.push_back(row(0, S0, 0, 0, 0, 0, 0, 0, 1,                          0, 0, 0, 2, 1, 32'h10C, 4'hF, 4, 0));
    tbl.push_back(row(0, S0, 0, 0, 0, 0, 0, 0, 1,                          0, 0, 0, 1, 1, 32'h110, 4'hF, 9, 0));
    tbl.push_back(row(0, S0, 0, 0, 0, 0, 0, 0, 1,                          0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Bubble loads and a flush on an uncommitted entry
    tbl.push_back(row(0, S0, 1, 32'h200, 1, 7, 4'hF, 32'h77, 0,            1, 7, 32'h77, 0, 0, 0, 0, 0, 0));
    tbl.push_back(row(0, SB, 1, 32'hDEADBEEF, 1, 31, 4'hF, 32'hDEADBEEF, 0, 0, 0, 0, 1, 1, 32'h200, 4'hF, 7, 0));
    tbl.push_back(row(0, SB, 1, 32'hDEADBEEF, 1, 31, 4'hF, 32'hDEADBEEF, 0, 0, 0, 0, 1, 1, 32'h200, 4'hF, 7, 0));
    tbl.push_back(row(0, S0, 1, 32'h300, 1, 8, 4'h1, 32'h88, 0,            1, 8, 32'h88, 1, 1, 32'h200, 4'hF, 7, 0));
    tbl.push_back(row(1, S0, 1, 32'hDEADBEEF, 1, 31, 4'hF, 32'hDEADBEEF, 0, 0, 0, 0, 2, 1, 32'h200, 4'hF, 7, 0));
    tbl.push_back(row(0, S0, 0, 0, 0, 0, 0, 0, 1,                          0, 0, 0, 1, 1, 32'h300, 4'h1, 8, 0));
    tbl.push_back(row(0, S0, 0, 0, 0, 0, 0, 0, 1,                          0, 0, 0, 0, 0, 0, 0, 0, 0));
    // MULT writes HI/LO only
    v = row(0, S0, 1, 32'h400, 0, 0, 4'hF, 0, 0,                           0, 0, 0, 0, 0, 0, 0, 0, 0);
    v.hi_we = 1'b1; v.lo_we = 1'b1; v.hi = 32'hFFFFFFFF; v.lo = 32'h00000001;
    v.e_hilo = {2'b11, 32'hFFFFFFFF, 32'h00000001};
    tbl.push_back(v);
    tbl.push_back(row(0, S0, 0, 0, 0, 0, 0, 0, 0,                          0, 0, 0, 1, 1, 32'h400, 4'h0, 0, 0));
    tbl.push_back(row(0, S0, 0, 0, 0, 0, 0, 0, 1,                          0, 0, 0, 0, 0, 0, 0, 0, 0));

    idle = row(0, S0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset state
    rst = 1'b1;
    drive(idle);
    tick();
    tick();
    chk_all_zero("reset");
    rst = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i]);
      tick();
      chk($sformatf("row%0d rf_we", i), 66'(rf_we), 66'(tbl[i].e_we));
      chk($sformatf("row%0d trace_count", i), 66'(trace_count), 66'(tbl[i].e_cnt));
      chk($sformatf("row%0d trace_valid", i), 66'(trace_valid), 66'(tbl[i].e_tv));
      chk($sformatf("row%0d stallreq_wb", i), 66'(stallreq_wb), 66'(tbl[i].e_sreq));
      chk($sformatf("row%0d hilo_bus", i), hilo_bus, tbl[i].e_hilo);
      if (tbl[i].e_we) begin
        chk($sformatf("row%0d rf_waddr", i), 66'(rf_waddr), 66'(tbl[i].e_waddr));
        chk($sformatf("row%0d rf_wdata", i), 66'(rf_wdata), 66'(tbl[i].e_wdata));
      end
      if (tbl[i].e_tv) begin
        chk($sformatf("row%0d trace_pc", i), 66'(trace_pc), 66'(tbl[i].e_tpc));
        chk($sformatf("row%0d trace_wen", i), 66'(trace_wen), 66'(tbl[i].e_twen));
        chk($sformatf("row%0d trace_wnum", i), 66'(trace_wnum), 66'(tbl[i].e_twnum));
      end
    end

    // Fill the FIFO, leave a fifth entry uncommitted, then reset mid-operation
    for (int k = 0; k < 5; k++) begin
      v = row(0, S0, 1, 32'h500 + 32'(4 * k), 1, 5'(10 + k), 4'hF, 32'(k + 1), 0,
              0, 0, 0, 0, 0, 0, 0, 0, 0);
      drive(v);
      tick();
    end
    chk("fill trace_count", 66'(trace_count), 66'd4);
    chk("fill stallreq_wb", 66'(stallreq_wb), 66'd1);
    chk("fill rf_we", 66'(rf_we), 66'd0);
    chk("fill rf_waddr", 66'(rf_waddr), 66'd14);
    stall = SH;
    rst = 1'b1;
    tick();
    chk_all_zero("midreset");
    rst = 1'b0;
    drive(idle);
    tick();
    chk("postreset trace_count", 66'(trace_count), 66'd0);
    chk("postreset trace_valid", 66'(trace_valid), 66'd0);
    chk("postreset rf_we", 66'(rf_we), 66'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
